// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
//   Time-multiplexes three decoded 7-segment patterns (ones, tens, hundreds)
//   onto one shared segment bus with per-digit enables. New results are
//   double-buffered so the visible digits only change at a frame wrap, and
//   leading-zero digits can optionally be blanked.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   load       in   1  capture seg1..seg3 on this clock edge
//   seg1       in   7  ones-digit pattern
//   seg2       in   7  tens-digit pattern
//   seg3       in   7  hundreds-digit pattern
//   seg_out    out  7  segment bus, registered, same encoding as the inputs
//   an         out  3  one-hot digit enables (bit0 = ones), registered,
//                      polarity set by ACTIVE_LOW_AN
//   frame_done out  1  one-cycle pulse after each D2 -> D0 wrap
// ---------------------------------------------------------------------------
module ssd_scan_driver #(
   parameter int         DIV           = 4,
   parameter bit         ACTIVE_LOW_AN = 1'b1,
   parameter logic [6:0] ZERO_PAT      = 7'b1111110,
   parameter bit         BLANK_LZ      = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [6:0] seg1,
   input  logic [6:0] seg2,
   input  logic [6:0] seg3,
   output logic [6:0] seg_out,
   output logic [2:0] an,
   output logic       frame_done
);

   // A one-bit counter is kept even for DIV = 1; it then stays at zero and
   // tick is permanently asserted.
   localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [2:0]       AN_OFF  = ACTIVE_LOW_AN ? 3'b111 : 3'b000;

   typedef enum logic [1:0] {
      D0 = 2'd0,
      D1 = 2'd1,
      D2 = 2'd2
   } digit_t;

   digit_t           idx;
   digit_t           idx_nxt;
   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic             wrap;
   logic [6:0]       sh1, sh2, sh3;
   logic [6:0]       dp1, dp2, dp3;
   logic             pending;
   logic             blank2;
   logic             blank3;
   logic [6:0]       seg_nxt;
   logic [2:0]       an_nxt;

   function automatic logic [2:0] an_drive(input logic [2:0] onehot);
      return ACTIVE_LOW_AN ? ~onehot : onehot;
   endfunction

   // ---- prescaler and digit index ----
   assign tick = (cnt == CNT_MAX);
   assign wrap = tick && (idx == D2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= D0;
      end else begin
         idx <= idx_nxt;
      end
   end

   always_comb begin
      idx_nxt = idx;
      if (tick) begin
         case (idx)
            D0:      idx_nxt = D1;
            D1:      idx_nxt = D2;
            default: idx_nxt = D0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= wrap;
      end
   end

   // ---- shadow / display double buffer ----
   // The display registers only move on a wrap. A load landing on the wrap
   // edge bypasses the shadow so the new value shows from this frame's D0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh1     <= '0;
         sh2     <= '0;
         sh3     <= '0;
         dp1     <= '0;
         dp2     <= '0;
         dp3     <= '0;
         pending <= 1'b0;
      end else if (wrap) begin
         if (load) begin
            dp1 <= seg1;
            dp2 <= seg2;
            dp3 <= seg3;
         end else if (pending) begin
            dp1 <= sh1;
            dp2 <= sh2;
            dp3 <= sh3;
         end
         pending <= 1'b0;
      end else if (load) begin
         sh1     <= seg1;
         sh2     <= seg2;
         sh3     <= seg3;
         pending <= 1'b1;
      end
   end

   // ---- leading-zero blanking and output register ----
   // Tens may only blank when hundreds is blank too; ones never blanks.
   assign blank3 = BLANK_LZ && (dp3 == ZERO_PAT);
   assign blank2 = blank3 && (dp2 == ZERO_PAT);

   always_comb begin
      seg_nxt = '0;
      an_nxt  = AN_OFF;
      case (idx)
         D0: begin
            seg_nxt = dp1;
            an_nxt  = an_drive(3'b001);
         end
         D1: begin
            if (!blank2) begin
               seg_nxt = dp2;
               an_nxt  = an_drive(3'b010);
            end
         end
         D2: begin
            if (!blank3) begin
               seg_nxt = dp3;
               an_nxt  = an_drive(3'b100);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_out <= '0;
         an      <= AN_OFF;
      end else begin
         seg_out <= seg_nxt;
         an      <= an_nxt;
      end
   end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
//   Two instances share all inputs: u_a (DIV=4, active-low enables, leading
//   zero blanking) and u_b (DIV=1, active-high enables, no blanking).
//   A behavioural model derives the digit slot and frame wrap from the
//   number of clock edges since reset and is compared on every falling edge.
//   A vector table plus hand-written sequences cover the scan, blanking,
//   anti-tearing, load-on-wrap, reset and DIV=1 corner cases.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

   localparam logic [6:0] ZP = 7'b1111110;

   localparam logic [2:0] B_AN  [7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
   localparam logic [6:0] B_SEG [7] = '{7'h00, 7'h00, 7'h00, 7'h30, 7'h6D, 7'h79, 7'h30};
   localparam logic       B_FD  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [6:0] seg1, seg2, seg3;
   logic [6:0] seg_a, seg_b;
   logic [2:0] an_a, an_b;
   logic       fd_a, fd_b;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;
   int a_seen = 0;

   always #5 clk = ~clk;

   ssd_scan_driver #(.DIV(4), .ACTIVE_LOW_AN(1'b1), .ZERO_PAT(ZP), .BLANK_LZ(1'b1)) u_a (
      .clk(clk), .rst(rst), .load(load), .seg1(seg1), .seg2(seg2), .seg3(seg3),
      .seg_out(seg_a), .an(an_a), .frame_done(fd_a));

   ssd_scan_driver #(.DIV(1), .ACTIVE_LOW_AN(1'b0), .ZERO_PAT(ZP), .BLANK_LZ(1'b0)) u_b (
      .clk(clk), .rst(rst), .load(load), .seg1(seg1), .seg2(seg2), .seg3(seg3),
      .seg_out(seg_b), .an(an_b), .frame_done(fd_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_a(input string nm, input logic [2:0] ean, input logic [6:0] eseg, input logic efd);
      chk({nm, ".an"},  32'(an_a),  32'(ean));
      chk({nm, ".seg"}, 32'(seg_a), 32'(eseg));
      chk({nm, ".fd"},  32'(fd_a),  32'(efd));
   endtask

   // ---- behavioural model ----
   int         me   [2];
   logic [6:0] disp [2][3];
   logic [6:0] shd  [2][3];
   bit         pend [2];
   logic [6:0] m_seg[2];
   logic [2:0] m_an [2];
   logic       m_fd [2];

   function automatic int  mdiv(input int i); return (i == 0) ? 4 : 1; endfunction
   function automatic bit  mlow(input int i); return (i == 0); endfunction
   function automatic bit  mblk(input int i); return (i == 0); endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         me[i]    = 0;
         pend[i]  = 1'b0;
         m_seg[i] = '0;
         m_an[i]  = mlow(i) ? 3'b111 : 3'b000;
         m_fd[i]  = 1'b0;
         for (int j = 0; j < 3; j++) begin
            disp[i][j] = '0;
            shd[i][j]  = '0;
         end
      end
   endtask

   task automatic model_step(input int i);
      int         d, k, dig;
      bit         wr, blank;
      logic [2:0] on;
      logic [6:0] cur [3];
      cur[0] = seg1; cur[1] = seg2; cur[2] = seg3;
      d   = mdiv(i);
      k   = me[i] % (3 * d);
      dig = k / d;
      wr  = (k == 3 * d - 1);
      // a digit other than ones is blank when it and every higher digit show zero
      blank = 1'b0;
      if (mblk(i) && dig > 0) begin
         blank = 1'b1;
         for (int j = dig; j < 3; j++)
            if (disp[i][j] != ZP) blank = 1'b0;
      end
      on = 3'b001 << dig;
      if (blank) begin
         m_an[i]  = mlow(i) ? 3'b111 : 3'b000;
         m_seg[i] = '0;
      end else begin
         m_an[i]  = mlow(i) ? ~on : on;
         m_seg[i] = disp[i][dig];
      end
      m_fd[i] = wr;
      if (wr) begin
         if (load) begin
            for (int j = 0; j < 3; j++) disp[i][j] = cur[j];
         end else if (pend[i]) begin
            for (int j = 0; j < 3; j++) disp[i][j] = shd[i][j];
         end
         pend[i] = 1'b0;
      end else if (load) begin
         for (int j = 0; j < 3; j++) shd[i][j] = cur[j];
         pend[i] = 1'b1;
      end
      me[i]++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else begin
            model_step(0);
            model_step(1);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("mdlA.seg", 32'(seg_a), 32'(m_seg[0]));
            chk("mdlA.an",  32'(an_a),  32'(m_an[0]));
            chk("mdlA.fd",  32'(fd_a),  32'(m_fd[0]));
            chk("mdlB.seg", 32'(seg_b), 32'(m_seg[1]));
            chk("mdlB.an",  32'(an_b),  32'(m_an[1]));
            chk("mdlB.fd",  32'(fd_b),  32'(m_fd[1]));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
      $fatal(1, "watchdog");
   end

   // ---- stimulus helpers ----
   task automatic step();
      @(negedge clk);
      if (seg_a inside {7'h06, 7'h5B, 7'h4F}) a_seen++;
   endtask

   task automatic align(input int m);
      int g = 0;
      while ((me[0] % 12) != m && g < 40) begin
         @(negedge clk);
         g++;
      end
      chk("align", 32'(me[0] % 12), 32'(m));
   endtask

   function automatic logic [6:0] rnd_seg();
      return ($urandom_range(0, 2) == 0) ? ZP : 7'($urandom);
   endfunction

   typedef struct {
      logic       ld;
      logic [6:0] s1, s2, s3;
      int         cyc;
      logic [2:0] an;
      logic [6:0] seg;
      logic       fd;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int fa, fb;
      // rows: load pulse on first cycle, run cyc edges, then expect u_a outputs
      tbl.push_back('{1'b0, 7'h00, 7'h00, 7'h00, 1, 3'b110, 7'h00, 1'b0});
      tbl.push_back('{1'b1, 7'h30, 7'h6D, 7'h79, 4, 3'b101, 7'h00, 1'b0});
      tbl.push_back('{1'b0, 7'h30, 7'h6D, 7'h79, 7, 3'b011, 7'h00, 1'b1});
      tbl.push_back('{1'b0, 7'h30, 7'h6D, 7'h79, 1, 3'b110, 7'h30, 1'b0});
      tbl.push_back('{1'b0, 7'h30, 7'h6D, 7'h79, 3, 3'b110, 7'h30, 1'b0});
      tbl.push_back('{1'b0, 7'h30, 7'h6D, 7'h79, 1, 3'b101, 7'h6D, 1'b0});
      tbl.push_back('{1'b0, 7'h30, 7'h6D, 7'h79, 4, 3'b011, 7'h79, 1'b0});
      tbl.push_back('{1'b0, 7'h30, 7'h6D, 7'h79, 3, 3'b011, 7'h79, 1'b1});
      tbl.push_back('{1'b0, 7'h30, 7'h6D, 7'h79, 1, 3'b110, 7'h30, 1'b0});
      tbl.push_back('{1'b1, 7'h30, ZP,    ZP,   11, 3'b011, 7'h79, 1'b1});
      tbl.push_back('{1'b0, 7'h30, ZP,    ZP,    1, 3'b110, 7'h30, 1'b0});
      tbl.push_back('{1'b0, 7'h30, ZP,    ZP,    4, 3'b111, 7'h00, 1'b0});
      tbl.push_back('{1'b0, 7'h30, ZP,    ZP,    4, 3'b111, 7'h00, 1'b0});
      tbl.push_back('{1'b1, 7'h30, 7'h30, ZP,    3, 3'b111, 7'h00, 1'b1});
      tbl.push_back('{1'b0, 7'h30, 7'h30, ZP,    1, 3'b110, 7'h30, 1'b0});
      tbl.push_back('{1'b0, 7'h30, 7'h30, ZP,    4, 3'b101, 7'h30, 1'b0});
      tbl.push_back('{1'b0, 7'h30, 7'h30, ZP,    4, 3'b111, 7'h00, 1'b0});

      rst = 1'b0; load = 1'b0; seg1 = '0; seg2 = '0; seg3 = '0;
      #1 rst = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_a("reset.a", 3'b111, 7'h00, 1'b0);
      chk("reset.b.an",  32'(an_b),  32'(3'b000));
      chk("reset.b.seg", 32'(seg_b), 32'(7'h00));
      #2 rst = 1'b0;

      // scan with load and leading-zero blanking
      for (int r = 0; r < tbl.size(); r++) begin
         load = tbl[r].ld; seg1 = tbl[r].s1; seg2 = tbl[r].s2; seg3 = tbl[r].s3;
         @(negedge clk);
         load = 1'b0;
         repeat (tbl[r].cyc - 1) @(negedge clk);
         chk_a($sformatf("tbl%0d", r), tbl[r].an, tbl[r].seg, tbl[r].fd);
      end

      // anti-tearing: A then B mid-frame, only B may ever appear
      align(1);
      a_seen = 0;
      load = 1'b1; seg1 = 7'h06; seg2 = 7'h5B; seg3 = 7'h4F;
      step();
      load = 1'b0;
      step();
      load = 1'b1; seg1 = 7'h66; seg2 = 7'h6D; seg3 = 7'h7D;
      step();
      load = 1'b0;
      step(); step();
      chk_a("tear.old", 3'b101, 7'h30, 1'b0);
      repeat (6) step();
      chk_a("tear.wrap", 3'b111, 7'h00, 1'b1);
      step();
      chk_a("tear.b1", 3'b110, 7'h66, 1'b0);
      repeat (4) step();
      chk_a("tear.b2", 3'b101, 7'h6D, 1'b0);
      repeat (4) step();
      chk_a("tear.b3", 3'b011, 7'h7D, 1'b0);
      chk("tear.a_never", 32'(a_seen), 32'(0));

      // load on the wrap edge discards older shadow data
      align(3);
      load = 1'b1; seg1 = 7'h39; seg2 = 7'h5E; seg3 = 7'h71;
      step();
      load = 1'b0;
      align(11);
      load = 1'b1; seg1 = 7'h07; seg2 = 7'h7F; seg3 = 7'h6F;
      step();
      load = 1'b0;
      chk_a("wrapld.edge", 3'b011, 7'h7D, 1'b1);
      step();
      chk_a("wrapld.d0", 3'b110, 7'h07, 1'b0);
      repeat (12) step();
      chk_a("wrapld.next", 3'b110, 7'h07, 1'b0);
      repeat (4) step();
      chk_a("wrapld.d1", 3'b101, 7'h7F, 1'b0);

      // asynchronous reset in the middle of a scan
      repeat (2) step();
      #2 rst = 1'b1;
      #1;
      chk_a("rst.async", 3'b111, 7'h00, 1'b0);
      chk("rst.async.b.an",  32'(an_b),  32'(3'b000));
      chk("rst.async.b.seg", 32'(seg_b), 32'(7'h00));
      @(negedge clk);
      chk_a("rst.hold", 3'b111, 7'h00, 1'b0);
      #2 rst = 1'b0;
      @(negedge clk);
      chk_a("rst.first", 3'b110, 7'h00, 1'b0);
      chk("rst.first.b.an",  32'(an_b),  32'(3'b001));
      chk("rst.first.b.seg", 32'(seg_b), 32'(7'h00));

      // DIV=1 rotation with a load on the first edge after reset
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      load = 1'b1; seg1 = 7'h30; seg2 = 7'h6D; seg3 = 7'h79;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         load = 1'b0;
         chk($sformatf("div1.%0d.an", k),  32'(an_b),  32'(B_AN[k]));
         chk($sformatf("div1.%0d.seg", k), 32'(seg_b), 32'(B_SEG[k]));
         chk($sformatf("div1.%0d.fd", k),  32'(fd_b),  32'(B_FD[k]));
      end

      // frame rate
      fa = 0; fb = 0;
      repeat (36) begin
         @(negedge clk);
         if (fd_a) fa++;
         if (fd_b) fb++;
      end
      chk("fdrate.a", 32'(fa), 32'(3));
      chk("fdrate.b", 32'(fb), 32'(12));

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            #2 rst = 1'b0;
         end
         load = ($urandom_range(0, 4) == 0);
         seg1 = rnd_seg();
         seg2 = rnd_seg();
         seg3 = rnd_seg();
      end
      load = 1'b0;
      repeat (4) @(negedge clk);
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
